// File: rtl/vector_mem_sequencer.sv
// Splits one VLEN-bit vector load/store into NBEATS MEM_W-bit memory beats. done pulses NBEATS+1 cycles after start at zero wait.
// Backpressure: each beat is held until mem_ack, and stall freezes the pipeline until the DONE cycle.
module vector_mem_sequencer #(
  parameter int VLEN   = 128,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [VLEN-1:0]   wdata_vec,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [VLEN-1:0]   rdata_vec,
  output logic              done,
  output logic              busy
);

  localparam int NBEATS = VLEN / MEM_W;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BYTES  = MEM_W / 8;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     beat;
  logic              st_q;
  logic [ADDR_W-1:0] base_q;
  logic [VLEN-1:0]   wdata_q;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_off;

  assign last_beat = (beat == BW'(NBEATS - 1));
  // Truncation to ADDR_W bits gives the modulo-2^ADDR_W wrap for free.
  assign beat_off  = ADDR_W'(beat) * ADDR_W'(BYTES);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = XFER;
      XFER:    if (mem_ack && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: stall = start;
      XFER: begin
        stall     = 1'b1;
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = st_q;
        mem_addr  = base_q + beat_off;
        mem_wdata = wdata_q[beat*MEM_W +: MEM_W];
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands are captured only on an accepted start; start while busy never re-latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat      <= '0;
      st_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      rdata_vec <= '0;
    end else if (state == IDLE && start) begin
      beat    <= '0;
      st_q    <= is_store;
      base_q  <= base_addr;
      wdata_q <= wdata_vec;
    end else if (state == XFER && mem_ack) begin
      if (!st_q) rdata_vec[beat*MEM_W +: MEM_W] <= mem_rdata;
      beat <= beat + BW'(1);
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: expected beats go to a scoreboard queue at start and are popped as the DUT presents them.
module tb_vector_mem_sequencer;

  localparam int VLEN   = 128;
  localparam int MEM_W  = 32;
  localparam int ADDR_W = 32;
  localparam int NBEATS = VLEN / MEM_W;

  typedef logic [VLEN-1:0] vec_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [MEM_W-1:0]  wdata;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [VLEN-1:0]   wdata_vec;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;
  logic              mem_ack;
  logic [VLEN-1:0]   rdata_vec;
  logic              done;
  logic              busy;

  vector_mem_sequencer #(.VLEN(VLEN), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .wdata_vec (wdata_vec),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .rdata_vec (rdata_vec),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t exp_q[$];
  vec_t  exp_rdata;
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},    vec_t'(busy),     '0);
    chk({tag, ".mem_req"}, vec_t'(mem_req),  '0);
    chk({tag, ".mem_we"},  vec_t'(mem_we),   '0);
    chk({tag, ".addr"},    vec_t'(mem_addr), '0);
    chk({tag, ".done"},    vec_t'(done),     '0);
    chk({tag, ".rdata"},   rdata_vec,        exp_rdata);
  endtask

  // rv holds the per-beat read data the memory returns; restart pokes start during XFER and DONE.
  task automatic run_op(input string tag, input logic st, input logic [ADDR_W-1:0] base,
                        input vec_t wv, input vec_t rv, input int waitc, input logic restart);
    int    exp_done;
    int    w;
    int    bi;
    logic  ack;
    beat_t b;
    exp_done = NBEATS * (waitc + 1) + 1;
    for (int i = 0; i < NBEATS; i++) begin
      b.addr  = base + ADDR_W'(i * (MEM_W / 8));
      b.we    = st;
      b.wdata = wv[i*MEM_W +: MEM_W];
      exp_q.push_back(b);
    end
    if (!st) exp_rdata = rv;

    @(negedge clk);
    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    wdata_vec = wv;
    mem_ack   = 1'b0;
    #1;
    chk({tag, ".c0.stall"}, vec_t'(stall), vec_t'(1'b1));
    chk({tag, ".c0.busy"},  vec_t'(busy),  '0);
    chk({tag, ".c0.done"},  vec_t'(done),  '0);

    w  = 0;
    bi = 0;
    for (int c = 1; c <= exp_done; c++) begin
      @(negedge clk);
      start = restart && (c == 2 || c == exp_done);
      if (restart) begin
        base_addr = base + 32'h1000;
        is_store  = ~st;
        wdata_vec = ~wv;
      end
      ack       = mem_req && (w == waitc);
      mem_ack   = ack;
      mem_rdata = (ack && !st) ? rv[bi*MEM_W +: MEM_W] : $urandom;
      #1;
      chk($sformatf("%s.c%0d.stall", tag, c), vec_t'(stall), vec_t'(c < exp_done));
      chk($sformatf("%s.c%0d.busy", tag, c),  vec_t'(busy),  vec_t'(1'b1));
      chk($sformatf("%s.c%0d.done", tag, c),  vec_t'(done),  vec_t'(c == exp_done));
      if (c < exp_done) begin
        chk($sformatf("%s.c%0d.req", tag, c), vec_t'(mem_req), vec_t'(1'b1));
        chk($sformatf("%s.c%0d.beat_left", tag, c), vec_t'(exp_q.size() != 0), vec_t'(1'b1));
        if (exp_q.size() != 0) begin
          chk($sformatf("%s.c%0d.addr", tag, c), vec_t'(mem_addr), vec_t'(exp_q[0].addr));
          chk($sformatf("%s.c%0d.we", tag, c),   vec_t'(mem_we),   vec_t'(exp_q[0].we));
          if (st) chk($sformatf("%s.c%0d.wdata", tag, c), vec_t'(mem_wdata), vec_t'(exp_q[0].wdata));
          if (ack) begin
            void'(exp_q.pop_front());
            bi++;
          end
        end
        if (ack) w = 0;
        else     w++;
      end else begin
        chk({tag, ".done.req"},   vec_t'(mem_req), '0);
        chk({tag, ".done.left"},  vec_t'(exp_q.size()), '0);
        chk({tag, ".done.rdata"}, rdata_vec, exp_rdata);
      end
    end

    @(negedge clk);
    start   = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk({tag, ".post.stall"}, vec_t'(stall), '0);
    chk_idle({tag, ".post"});
    exp_q.delete();
  endtask

  initial begin
    vec_t rv;
    vec_t wv;
    rst_n     = 1'b0;
    start     = 1'b1;
    is_store  = 1'b1;
    base_addr = '1;
    wdata_vec = '1;
    mem_ack   = 1'b1;
    mem_rdata = '1;
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    start   = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset.stall", vec_t'(stall), '0);
    chk("reset.wdata", vec_t'(mem_wdata), '0);
    @(negedge clk);
    #1;
    chk_idle("reset.start_ignored");

    rv = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    run_op("ld_zero_wait", 1'b0, 32'h0000_0100, '0, rv, 0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
      #1;
      chk_idle($sformatf("stray_ack%0d", i));
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk_idle("stray_ack.after");

    wv = {{8{4'hD}}, {8{4'hC}}, {8{4'hB}}, {8{4'hA}}};
    rv = {$urandom, $urandom, $urandom, $urandom};
    run_op("st_wait2", 1'b1, 32'h0000_0200, wv, rv, 2, 1'b0);

    rv = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    run_op("ld_wrap", 1'b0, 32'hFFFF_FFF8, '0, rv, 1, 1'b0);

    rv = {$urandom, $urandom, $urandom, $urandom};
    run_op("ld_restart", 1'b0, 32'h0000_0400, {$urandom, $urandom, $urandom, $urandom}, rv, 0, 1'b1);

    rv = {32'h0BAD0004, 32'h0BAD0003, 32'h0BAD0002, 32'h0BAD0001};
    @(negedge clk);
    start     = 1'b1;
    is_store  = 1'b0;
    base_addr = 32'h0000_0500;
    mem_ack   = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      start     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = rv[(c-1)*MEM_W +: MEM_W];
      #1;
      chk($sformatf("abort.c%0d.addr", c), vec_t'(mem_addr), vec_t'(32'h0000_0500 + 32'(4 * (c - 1))));
    end
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("abort.partial_rdata", rdata_vec, {exp_rdata[VLEN-1:64], rv[63:0]});
    chk("abort.req_before", vec_t'(mem_req), vec_t'(1'b1));
    @(negedge clk);
    rst_n     = 1'b1;
    exp_rdata = '0;
    #1;
    chk_idle("abort.next");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort.nodone%0d", i), vec_t'(done), '0);
      chk($sformatf("abort.nobusy%0d", i), vec_t'(busy), '0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 Parameters SHALL be: VLEN, default 128, vector register width in bits; MEM_W, default 32, data-memory port width in bits; ADDR_W, default 32, byte-address width.
REQ-002 VLEN SHALL be an integer multiple of MEM_W, giving NBEATS = VLEN/MEM_W; the defaults give 4 beats.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  execute stage issues a vector memory op (strv/ldrv, MemSrc=1).
REQ-006 is_store  input  1  1 = strv, 0 = ldrv; sampled with start.
REQ-007 base_addr  input  ADDR_W  byte address from the ALU; sampled with start.
REQ-008 wdata_vec  input  VLEN  vector store data; sampled with start.
REQ-009 stall  output  1  freezes fetch/decode/execute while the op is in flight.
REQ-010 mem_req  output  1  memory beat request.
REQ-011 mem_we  output  1  beat is a write.
REQ-012 mem_addr  output  ADDR_W  beat byte address.
REQ-013 mem_wdata  output  MEM_W  beat write data.
REQ-014 mem_rdata  input  MEM_W  beat read data, valid with mem_ack.
REQ-015 mem_ack  input  1  memory completes the current beat.
REQ-016 rdata_vec  output  VLEN  assembled load result for the vector writeback (RegWV).
REQ-017 done  output  1  one-cycle pulse when the op completes.
REQ-018 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, XFER and DONE.
REQ-020 IDLE -> XFER on start=1, latching is_store, base_addr and wdata_vec, and clearing the beat counter to 0.
REQ-021 In XFER the block SHALL drive mem_req=1, mem_we=latched is_store, mem_addr=base+beat*(MEM_W/8) and mem_wdata=wdata_vec[beat*MEM_W +: MEM_W].
REQ-022 These outputs SHALL be held stable until a cycle with mem_ack=1.
REQ-023 On mem_ack in XFER: for a load, rdata_vec[beat*MEM_W +: MEM_W] <= mem_rdata; beat <= beat+1.
REQ-024 On mem_ack for beat NBEATS-1 the FSM SHALL move XFER -> DONE.
REQ-025 In DONE the block SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-026 mem_req, mem_we and mem_addr SHALL be 0 outside XFER.
REQ-027 stall SHALL equal (state==IDLE && start) || state==XFER.
REQ-028 stall SHALL be 0 in DONE, so the pipeline advances in the same cycle done pulses.
REQ-029 Latency with zero-wait memory (mem_ack tied 1): start in cycle 0, beats in cycles 1..NBEATS, done in cycle NBEATS+1.
REQ-030 Each memory wait cycle SHALL add exactly one cycle of latency.
REQ-031 Beat address arithmetic SHALL be modulo 2^ADDR_W; wrap past 0xFFFFFFFF continues at 0x00000000.
REQ-032 start while busy=1 SHALL be ignored: no re-latching and no queueing.
REQ-033 start in DONE SHALL also be ignored; the pipeline is stalled until DONE releases it.
REQ-034 mem_ack outside XFER SHALL be ignored.
REQ-035 mem_rdata SHALL be ignored when mem_ack=0 or on store beats.
REQ-036 rdata_vec SHALL change only on load beats and SHALL hold its value across stores and idle cycles.
REQ-037 A partially completed load SHALL leave its already-written beat slices updated in rdata_vec.

Reset
REQ-038 While rst_n=0 at a clock edge: state<=IDLE, beat<=0, rdata_vec<=0, all latched operands <=0.
REQ-039 All outputs SHALL therefore read 0 in the cycle after reset.
REQ-040 Reset during XFER or DONE SHALL abort the op, with no done pulse and mem_req low on the next cycle.
REQ-041 start coincident with rst_n=0 SHALL be ignored.

Verification
REQ-042 Zero-wait ldrv: base=0x100, rdata beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> addresses 0x100/104/108/10C in cycles 1-4, done in cycle 5, rdata_vec=0x44444444_33333333_22222222_11111111.
REQ-043 strv with wait states: wdata_vec=0xDDDD..._AAAA..., ack delayed 2 cycles per beat -> each beat's addr/wdata held stable, mem_we=1, done in cycle 13, stall high in cycles 0-12, rdata_vec unchanged.
REQ-044 Address wrap: base=0xFFFFFFF8 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-045 start pulsed again during XFER with a different base -> ignored; the original 4 addresses complete and exactly one done pulse occurs.
REQ-046 rst_n=0 after beat 1 ack of a load -> next cycle busy=0, mem_req=0, done never pulses, rdata_vec=0.
REQ-047 Stray mem_ack=1 in IDLE -> rdata_vec, state and outputs unchanged.
